// File: rtl/mult_hilo_ctrl.sv
// Sequencer for an iterative shift-add multiplier: latches operands, walks the
// multiplier through load/iterate/output, captures the 64-bit product into HI/LO.
module mult_hilo_ctrl #(
    parameter logic [5:0] MULT_CODE = 6'b011001,
    parameter logic [5:0] OUT_CODE  = 6'b111111,
    parameter logic [5:0] IDLE_CODE = 6'b000000,
    parameter int         ITER      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic [63:0] mul_product,
    output logic        mul_load,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [5:0]  mul_signal,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_OUT,
        S_CAPTURE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        mul_a_q, mul_a_d;
    logic [31:0]        mul_b_q, mul_b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               done_q, done_d;

    // Reset clears the operand and result registers as well as control.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        mul_signal = IDLE_CODE;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mul_a_d = op_a;
                    mul_b_d = op_b;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                mul_signal = MULT_CODE;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                mul_signal = OUT_CODE;
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Multiplier output register was loaded at the end of OUT.
                hi_d    = mul_product[63:32];
                lo_d    = mul_product[31:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mul_load = reset | (state_q == S_LOAD);
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign stall    = busy & (mfhi | mflo);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign rd_data  = mfhi ? hi_q : (mflo ? lo_q : 32'h0);

endmodule

// File: doc/mult_hilo_ctrl.md
MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 Parameter MULT_CODE, default 6'b011001, Signal code that commands one shift-add iteration.
REQ-002 Parameter OUT_CODE, default 6'b111111, Signal code that commands the product to move to the multiplier output register.
REQ-003 Parameter IDLE_CODE, default 6'b000000, Signal code the multiplier ignores.
REQ-004 Parameter ITER, default 32, number of MULT iterations per operation.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request a new unsigned multiply of op_a by op_b.
REQ-008 op_a  input  32  multiplicand, sampled when start is accepted.
REQ-009 op_b  input  32  multiplier operand, sampled when start is accepted.
REQ-010 mfhi  input  1  read request for HI.
REQ-011 mflo  input  1  read request for LO.
REQ-012 mul_product  input  64  product returned by the downstream multiplier.
REQ-013 mul_load  output  1  drives the multiplier reset/load port.
REQ-014 mul_a  output  32  operand A presented to the multiplier.
REQ-015 mul_b  output  32  operand B presented to the multiplier.
REQ-016 mul_signal  output  6  command code presented to the multiplier.
REQ-017 busy  output  1  an operation is in progress.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 stall  output  1  a read is requested while an operation is in progress.
REQ-020 hi  output  32  HI register.
REQ-021 lo  output  32  LO register.
REQ-022 rd_data  output  32  read data for mfhi or mflo.

Function
REQ-023 The FSM SHALL have states IDLE, LOAD, RUN, OUT, CAPTURE, encoded in registers.
REQ-024 IDLE: start=1 SHALL latch op_a/op_b into mul_a/mul_b and go to LOAD; start=0 stays IDLE.
REQ-025 LOAD (1 cycle): mul_load=1, mul_signal=IDLE_CODE, iteration counter cleared to 0; next state RUN.
REQ-026 RUN: mul_signal=MULT_CODE, counter increments each cycle; after exactly ITER RUN cycles go to OUT.
REQ-027 OUT (1 cycle): mul_signal=OUT_CODE; next state CAPTURE.
REQ-028 CAPTURE (1 cycle): mul_signal=IDLE_CODE; at the end-of-cycle edge hi<=mul_product[63:32] and lo<=mul_product[31:0]; next state IDLE.
REQ-029 mul_load SHALL be 1 in LOAD and whenever reset=1, and 0 otherwise.
REQ-030 mul_signal SHALL be IDLE_CODE in IDLE.
REQ-031 mul_a and mul_b SHALL stay constant from the edge that accepts start until the next accepted start.
REQ-032 busy SHALL be 1 in LOAD, RUN, OUT and CAPTURE, and 0 in IDLE.
REQ-033 done SHALL be a registered pulse, high for exactly the one cycle after CAPTURE, the first cycle in which hi/lo show the new product.
REQ-034 Latency: start accepted at edge N -> done high in cycle N+36 (LOAD 1, RUN 32, OUT 1, CAPTURE 1, then the done cycle).
REQ-035 start while busy=1 SHALL be ignored: no latch, no queue, no effect on the current operation.
REQ-036 start in the done cycle (state IDLE) SHALL be accepted normally.
REQ-037 rd_data is combinational: mfhi=1 gives hi (mfhi wins if mflo is also 1); mflo=1 alone gives lo; neither gives 0.
REQ-038 During busy, rd_data SHALL return the current (old) register value.
REQ-039 stall SHALL equal busy & (mfhi | mflo).
REQ-040 The product is treated as unsigned 64-bit; no sign handling and no overflow flag.

Reset
REQ-041 reset=1 at any edge SHALL force: state IDLE, counter 0, hi=0, lo=0, mul_a=0, mul_b=0, busy=0, done=0, mul_signal=IDLE_CODE.
REQ-042 reset SHALL take priority over start and abort any operation in progress; hi/lo are not updated from the aborted operation.

Verification
REQ-043 op_a=3, op_b=5, start pulse at edge 0 -> busy cycles 1..35; mul_signal=MULT_CODE for exactly 32 cycles; done in cycle 36; hi=0, lo=0x0000000F.
REQ-044 op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at done.
REQ-045 start re-asserted with op_a=7 during RUN -> ignored; mul_a unchanged; result still from the original operands.
REQ-046 reset asserted on the 10th RUN cycle -> next cycle IDLE, busy=0, hi=lo=0, mul_load=1 during reset, no done pulse.
REQ-047 hi=0x12345678, lo=0x9ABCDEF0 idle; mfhi=mflo=1 -> rd_data=0x12345678, stall=0; mflo alone during busy -> rd_data=0x9ABCDEF0, stall=1.
REQ-048 Back-to-back: start held high through done -> second operation accepted in the done cycle; second done exactly 36 cycles later.
